// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit.
package ctrl_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_AND  = 4'd8,
    ALU_SUB  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  localparam logic [1:0] TRAP_NONE     = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL  = 2'b01;
  localparam logic [1:0] TRAP_FETCH_TO = 2'b10;
  localparam logic [1:0] TRAP_DATA_TO  = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Opcodes this unit knows how to sequence; anything else traps.
  function automatic logic opcode_legal(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU operation decode from opcode, funct3 and instr[30].
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       bit30_i,
  output logic [3:0] alu_op_o
);

  alu_op_e alu_op;

  // instr[30] means sub only for register-register ops; it means sra for both forms.
  always_comb begin
    alu_op = ALU_ADD;
    if (opcode_i == OPC_OP || opcode_i == OPC_OP_IMM) begin
      case (funct3_i)
        3'b000:  alu_op = (opcode_i == OPC_OP && bit30_i) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = bit30_i ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        3'b111:  alu_op = ALU_AND;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign alu_op_o = alu_op;

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// wait-limited memory handshakes, retired-instruction counter and sticky traps.
module mc_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         imem_rdata_i,
  input  logic                imem_ack_i,
  input  logic                dmem_ack_i,
  input  logic                br_less_i,
  input  logic                br_equal_i,
  output logic [31:0]         instr_o,
  output logic                imem_req_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [1:0]          dmem_size_o,
  output logic                dmem_unsigned_o,
  output logic                br_unsigned_o,
  output logic                pc_wren_o,
  output logic                pc_sel_o,
  output logic                rd_wren_o,
  output logic                op_a_sel_o,
  output logic                op_b_sel_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [1:0]          wb_sel_o,
  output logic                retire_o,
  output logic [CNT_W-1:0]    instret_o,
  output logic                trap_o,
  output logic [1:0]          trap_cause_o
);

  localparam int unsigned      WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  state_e              state_q, state_d;
  logic [31:0]         instr_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [CNT_W-1:0]    instret_q;
  logic                trap_q;
  logic [1:0]          cause_q, cause_d;
  logic                sel_en;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] alu_op_dec;
  logic       is_load, is_store, is_op, is_branch;
  logic       is_jal, is_jalr, is_lui, is_auipc;
  logic       br_taken;

  assign opcode    = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_op     = (opcode == OPC_OP);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);

  alu_dec u_alu_dec (
    .opcode_i (opcode),
    .funct3_i (funct3),
    .bit30_i  (instr_q[30]),
    .alu_op_o (alu_op_dec)
  );

  // Branch condition from the comparator; funct3 010/011 are never taken.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:          br_taken = br_equal_i;
      3'b001:          br_taken = !br_equal_i;
      3'b100, 3'b110:  br_taken = br_less_i;
      3'b101, 3'b111:  br_taken = !br_less_i;
      default:         br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Next state and all control outputs, decoded from state and instruction register.
  always_comb begin
    state_d         = state_q;
    cause_d         = TRAP_NONE;
    sel_en          = 1'b0;
    imem_req_o      = 1'b0;
    dmem_req_o      = 1'b0;
    dmem_we_o       = 1'b0;
    dmem_size_o     = 2'b00;
    dmem_unsigned_o = 1'b0;
    br_unsigned_o   = 1'b0;
    pc_wren_o       = 1'b0;
    pc_sel_o        = 1'b0;
    rd_wren_o       = 1'b0;
    op_a_sel_o      = 1'b0;
    op_b_sel_o      = 1'b0;
    alu_op_o        = '0;
    wb_sel_o        = WB_ALU;
    retire_o        = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // Held low while reset is asserted so a pending request drops at once.
        imem_req_o = !rst_i;
        if (imem_ack_i) begin
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_TRAP;
          cause_d = TRAP_FETCH_TO;
        end
      end
      ST_DECODE: begin
        if (opcode_legal(opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = TRAP_ILLEGAL;
        end
      end
      ST_EXEC: begin
        sel_en = 1'b1;
        if (is_load || is_store) begin
          state_d = ST_MEM;
        end else if (is_branch) begin
          pc_sel_o      = br_taken;
          br_unsigned_o = funct3[2] & funct3[1];
          pc_wren_o     = 1'b1;
          retire_o      = 1'b1;
          state_d       = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        sel_en          = 1'b1;
        dmem_req_o      = 1'b1;
        dmem_we_o       = is_store;
        dmem_size_o     = funct3[1:0];
        dmem_unsigned_o = is_load & funct3[2];
        if (dmem_ack_i) begin
          if (is_load) begin
            state_d = ST_WB;
          end else begin
            pc_wren_o = 1'b1;
            retire_o  = 1'b1;
            state_d   = ST_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_TRAP;
          cause_d = TRAP_DATA_TO;
        end
      end
      ST_WB: begin
        sel_en    = 1'b1;
        rd_wren_o = 1'b1;
        pc_wren_o = 1'b1;
        retire_o  = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    if (sel_en) begin
      alu_op_o   = ALU_OP_W'(alu_op_dec);
      op_a_sel_o = is_auipc | is_jal | is_branch;
      op_b_sel_o = !is_op;
      if (is_jal || is_jalr) pc_sel_o = 1'b1;
      if (is_lui)                 wb_sel_o = WB_IMM;
      else if (is_load)           wb_sel_o = WB_LOAD;
      else if (is_jal || is_jalr) wb_sel_o = WB_PC4;
      else                        wb_sel_o = WB_ALU;
    end
  end

  // Instruction register, wait counter, retired counter and sticky trap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q   <= NOP_INSTR;
      wait_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= TRAP_NONE;
    end else begin
      if (state_q == ST_FETCH && imem_ack_i) instr_q <= imem_rdata_i;

      if (state_d != state_q) begin
        wait_q <= '0;
      end else if ((state_q == ST_FETCH && !imem_ack_i) ||
                   (state_q == ST_MEM && !dmem_ack_i)) begin
        wait_q <= wait_q + WAIT_W'(1);
      end

      if (retire_o) instret_q <= instret_q + CNT_W'(1);

      if (state_d == ST_TRAP && state_q != ST_TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= cause_d;
      end
    end
  end

  assign instr_o      = instr_q;
  assign instret_o    = instret_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit: directed and random instructions
// against a per-instruction reference of expected control outputs.
module tb_mc_ctrl_unit;

  localparam int unsigned WAIT_MAX = 4;
  localparam int unsigned CNT_W    = 4;

  localparam int K_OP = 0, K_IMM = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4;
  localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic [31:0]      imem_rdata_i = '0;
  logic             imem_ack_i = 1'b0;
  logic             dmem_ack_i = 1'b0;
  logic             br_less_i = 1'b0;
  logic             br_equal_i = 1'b0;
  logic [31:0]      instr_o;
  logic             imem_req_o, dmem_req_o, dmem_we_o;
  logic [1:0]       dmem_size_o;
  logic             dmem_unsigned_o, br_unsigned_o, pc_wren_o, pc_sel_o;
  logic             rd_wren_o, op_a_sel_o, op_b_sel_o;
  logic [3:0]       alu_op_o;
  logic [1:0]       wb_sel_o;
  logic             retire_o;
  logic [CNT_W-1:0] instret_o;
  logic             trap_o;
  logic [1:0]       trap_cause_o;

  mc_ctrl_unit #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W), .ALU_OP_W(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .imem_rdata_i    (imem_rdata_i),
    .imem_ack_i      (imem_ack_i),
    .dmem_ack_i      (dmem_ack_i),
    .br_less_i       (br_less_i),
    .br_equal_i      (br_equal_i),
    .instr_o         (instr_o),
    .imem_req_o      (imem_req_o),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_size_o     (dmem_size_o),
    .dmem_unsigned_o (dmem_unsigned_o),
    .br_unsigned_o   (br_unsigned_o),
    .pc_wren_o       (pc_wren_o),
    .pc_sel_o        (pc_sel_o),
    .rd_wren_o       (rd_wren_o),
    .op_a_sel_o      (op_a_sel_o),
    .op_b_sel_o      (op_b_sel_o),
    .alu_op_o        (alu_op_o),
    .wb_sel_o        (wb_sel_o),
    .retire_o        (retire_o),
    .instret_o       (instret_o),
    .trap_o          (trap_o),
    .trap_cause_o    (trap_cause_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic [1:0] size;
    logic       uns;
    logic       bru;
    logic       pc_wren;
    logic       pc_sel;
    logic       rd_wren;
    logic       a_sel;
    logic       b_sel;
    logic [3:0] alu;
    logic [1:0] wb;
    logic       retire;
  } ov_t;

  int n_assert = 0;
  int n_fail   = 0;
  int retired  = 0;

  logic [6:0] opc_tab [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                              7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                              7'b0010111};
  int f3_code [8] = '{0, 1, 2, 3, 4, 5, 7, 8};
  int lat_tab [9] = '{4, 4, 5, 4, 3, 4, 4, 4, 4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input ov_t e);
    ov_t o;
    o.imem_req = imem_req_o;   o.dmem_req = dmem_req_o;   o.dmem_we = dmem_we_o;
    o.size     = dmem_size_o;  o.uns      = dmem_unsigned_o;
    o.bru      = br_unsigned_o; o.pc_wren = pc_wren_o;    o.pc_sel  = pc_sel_o;
    o.rd_wren  = rd_wren_o;    o.a_sel    = op_a_sel_o;   o.b_sel   = op_b_sel_o;
    o.alu      = alu_op_o;     o.wb       = wb_sel_o;     o.retire  = retire_o;
    check(tag, {13'b0, o}, {13'b0, e});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int kind_of(input logic [6:0] opc);
    for (int k = 0; k < 9; k++) if (opc_tab[k] == opc) return k;
    return -1;
  endfunction

  function automatic logic [31:0] rand_instr(input int k);
    logic [31:0] w;
    logic [2:0]  f3;
    int          p;
    w  = $urandom();
    f3 = w[14:12];
    p  = $urandom_range(0, 4);
    if (k == K_LOAD)  f3 = (p < 3) ? 3'(p) : 3'(p + 1);
    if (k == K_STORE) f3 = 3'($urandom_range(0, 2));
    if (k == K_JALR)  f3 = 3'b000;
    w[14:12] = f3;
    w[6:0]   = opc_tab[k];
    return w;
  endfunction

  task automatic check_trap(input string tag, input logic [1:0] cause);
    check({tag, "_flag"}, 32'(trap_o), 32'd1);
    check({tag, "_cause"}, 32'(trap_cause_o), 32'(cause));
    check_outs({tag, "_outs"}, '0);
    check({tag, "_instret"}, 32'(instret_o), 32'(retired % 16));
  endtask

  // Drive one instruction from FETCH; iw/dw are wait cycles before each ack.
  // dw >= WAIT_MAX withholds the data ack entirely.
  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                           input logic less, input logic eq);
    int k, cyc, ret_cnt, ret_idx, n;
    logic [2:0] f3;
    logic taken;
    ov_t s, e;
    k = kind_of(ins[6:0]);
    f3 = ins[14:12];
    cyc = 0; ret_cnt = 0; ret_idx = -1;

    s = '0;
    if (k == K_OP || k == K_IMM) begin
      s.alu = 4'(f3_code[f3]);
      if (f3 == 3'd5 && ins[30]) s.alu = 4'd6;
      if (k == K_OP && f3 == 3'd0 && ins[30]) s.alu = 4'd9;
    end
    s.a_sel  = (k == K_AUIPC || k == K_JAL || k == K_BR);
    s.b_sel  = (k != K_OP);
    s.wb     = (k == K_LUI) ? 2'd3 : (k == K_LOAD) ? 2'd1 :
               (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
    s.pc_sel = (k == K_JAL || k == K_JALR);
    case (f3)
      3'd0:       taken = eq;
      3'd1:       taken = !eq;
      3'd4, 3'd6: taken = less;
      3'd5, 3'd7: taken = !less;
      default:    taken = 1'b0;
    endcase

    for (int i = 0; i <= iw; i++) begin
      imem_ack_i   = (i == iw);
      imem_rdata_i = (i == iw) ? ins : 32'($urandom());
      #1;
      e = '0; e.imem_req = 1'b1;
      check_outs("fetch", e);
      next_cycle(); cyc++;
    end
    imem_ack_i   = 1'b0;
    imem_rdata_i = 32'($urandom());
    #1;
    check_outs("decode", '0);
    check("instr_reg", instr_o, ins);
    next_cycle(); cyc++;
    if (k < 0) begin
      #1;
      check_trap("illegal", 2'b01);
      return;
    end

    br_less_i = less; br_equal_i = eq;
    #1;
    e = s;
    if (k == K_BR) begin
      e.pc_sel = taken; e.bru = f3[2] & f3[1];
      e.pc_wren = 1'b1; e.retire = 1'b1;
    end
    check_outs("exec", e);
    if (retire_o) begin ret_cnt++; ret_idx = cyc; end
    next_cycle(); cyc++;

    if (k == K_LOAD || k == K_STORE) begin
      n = (dw < int'(WAIT_MAX)) ? dw + 1 : int'(WAIT_MAX);
      for (int i = 0; i < n; i++) begin
        dmem_ack_i = (i == dw);
        #1;
        e = s; e.dmem_req = 1'b1; e.dmem_we = (k == K_STORE);
        e.size = f3[1:0]; e.uns = (k == K_LOAD) && f3[2];
        if (k == K_STORE && i == dw) begin e.pc_wren = 1'b1; e.retire = 1'b1; end
        check_outs("mem", e);
        if (retire_o) begin ret_cnt++; ret_idx = cyc; end
        next_cycle(); cyc++;
      end
      dmem_ack_i = 1'b0;
      if (dw >= int'(WAIT_MAX)) begin
        #1;
        check_trap("data_to", 2'b11);
        return;
      end
    end

    if (k != K_BR && k != K_STORE) begin
      #1;
      e = s; e.rd_wren = 1'b1; e.pc_wren = 1'b1; e.retire = 1'b1;
      check_outs("wb", e);
      if (retire_o) begin ret_cnt++; ret_idx = cyc; end
      next_cycle(); cyc++;
    end

    retired++;
    check("retire_pulses", 32'(ret_cnt), 32'd1);
    check("latency", 32'(ret_idx),
          32'(lat_tab[k] - 1 + iw + ((k == K_LOAD || k == K_STORE) ? dw : 0)));
    check("instret", 32'(instret_o), 32'(retired % 16));
  endtask

  // Asynchronous reset; outputs must clear before any clock edge, late acks ignored.
  task automatic do_reset();
    rst_i = 1'b1;
    imem_ack_i = 1'b1;
    dmem_ack_i = 1'b1;
    #1;
    check_outs("rst_outs", '0);
    check("rst_instr", instr_o, 32'h0000_0013);
    check("rst_instret", 32'(instret_o), 32'd0);
    check("rst_trap", {30'b0, trap_o, 1'b0} | 32'(trap_cause_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    rst_i = 1'b0;
    retired = 0;
  endtask

  initial begin
    #2;
    do_reset();

    // addi x1,x0,5 then sub x3,x1,x2
    run_instr({12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011}, 0, 0, 1'b0, 1'b0);
    run_instr({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 0, 0, 1'b0, 1'b0);
    check("instret_two", 32'(instret_o), 32'd2);

    // bltu with less (taken), bge with less (not taken)
    run_instr({7'd0, 5'd2, 5'd1, 3'b110, 5'd8, 7'b1100011}, 0, 0, 1'b1, 1'b0);
    run_instr({7'd0, 5'd2, 5'd1, 3'b101, 5'd8, 7'b1100011}, 0, 0, 1'b1, 1'b0);

    // lw with a 3-cycle data delay, sb with zero wait
    run_instr({12'd4, 5'd1, 3'b010, 5'd5, 7'b0000011}, 0, 3, 1'b0, 1'b0);
    run_instr({7'd0, 5'd5, 5'd1, 3'b000, 5'd0, 7'b0100011}, 0, 0, 1'b0, 1'b0);

    // Ack in the last allowed wait cycle for fetch and data
    run_instr({12'd1, 5'd2, 3'b000, 5'd2, 7'b0010011}, 3, 0, 1'b0, 1'b0);
    run_instr({12'd8, 5'd1, 3'b100, 5'd6, 7'b0000011}, 3, 3, 1'b0, 1'b0);
    // srai and lui/auipc/jal/jalr
    run_instr({7'b0100000, 5'd3, 5'd1, 3'b101, 5'd7, 7'b0010011}, 0, 0, 1'b0, 1'b0);
    run_instr({20'hABCDE, 5'd9, 7'b0110111}, 1, 0, 1'b0, 1'b0);
    run_instr({20'h00010, 5'd9, 7'b0010111}, 0, 0, 1'b0, 1'b0);
    run_instr({20'h00100, 5'd1, 7'b1101111}, 2, 0, 1'b0, 1'b0);
    run_instr({12'd16, 5'd1, 3'b000, 5'd0, 7'b1100111}, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 8);
      run_instr(rand_instr(k), $urandom_range(0, WAIT_MAX - 1),
                $urandom_range(0, WAIT_MAX - 1),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a fetch request
    imem_ack_i = 1'b0;
    #1;
    check("mid_fetch_req", 32'(imem_req_o), 32'd1);
    #1;
    do_reset();

    // 16 retirements wrap a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      int k;
      k = $urandom_range(0, 8);
      run_instr(rand_instr(k), $urandom_range(0, 1), $urandom_range(0, 1),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check("instret_wrap", 32'(instret_o), 32'd0);

    // Fetch timeout: no ack for WAIT_MAX cycles, then trap holds
    run_instr({12'd3, 5'd0, 3'b000, 5'd4, 7'b0010011}, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < int'(WAIT_MAX); i++) begin
      imem_ack_i = 1'b0;
      #1;
      check("fetch_to_req", 32'(imem_req_o), 32'd1);
      next_cycle();
    end
    #1;
    check_trap("fetch_to", 2'b10);
    imem_ack_i = 1'b1;
    repeat (3) next_cycle();
    #1;
    check_trap("fetch_to_sticky", 2'b10);
    do_reset();

    // Data timeout on a load
    run_instr({12'd0, 5'd1, 3'b010, 5'd2, 7'b0000011}, 0, WAIT_MAX, 1'b0, 1'b0);
    do_reset();

    // Illegal opcodes trap without retiring
    run_instr({12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011}, 0, 0, 1'b0, 1'b0);
    run_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0);
    imem_ack_i = 1'b1;
    repeat (2) next_cycle();
    #1;
    check_trap("illegal_sticky", 2'b01);
    do_reset();
    run_instr({12'd0, 5'd0, 3'b000, 5'd0, 7'b1110011}, 1, 0, 1'b0, 1'b0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_unit.md
# mc_ctrl_unit

Multi-cycle RV32I control unit: a sequencing FSM that fetches, decodes, executes, accesses memory and writes back one instruction at a time. It owns the instruction register and drives the datapath selects, register-file and PC write enables, and ready/ack memory handshakes. Over the single-cycle control decode it adds variable-latency memories, `lui`/`auipc`, load/store size decode, a retired-instruction counter, and sticky traps.

## Interface
- `WAIT_MAX`, default 16: maximum wait cycles on any memory request before trapping; minimum 1.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `ALU_OP_W`, default 4: width of `alu_op_o`.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `imem_rdata_i`  in  32  instruction word, valid when `imem_ack_i`=1.
- `imem_ack_i`  in  1  instruction fetch complete.
- `dmem_ack_i`  in  1  data access complete.
- `br_less_i`, `br_equal_i`  in  1 each  comparator results for rs1/rs2.
- `instr_o`  out  32  instruction register contents.
- `imem_req_o`  out  1  fetch request.
- `dmem_req_o`, `dmem_we_o`  out  1 each  data request, write enable.
- `dmem_size_o`  out  2  00 byte, 01 half, 10 word (funct3[1:0]).
- `dmem_unsigned_o`  out  1  funct3[2] for loads.
- `br_unsigned_o`  out  1  selects unsigned compare (`bltu`, `bgeu`).
- `pc_wren_o`, `pc_sel_o`  out  1 each  PC update strobe; target select: 0 = pc+4, 1 = ALU result.
- `rd_wren_o`, `op_a_sel_o`, `op_b_sel_o`  out  1 each  register-file write; A: 0 = rs1, 1 = pc; B: 0 = rs2, 1 = imm.
- `alu_op_o`  out  ALU_OP_W  0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl, 6 sra, 7 or, 8 and, 9 sub.
- `wb_sel_o`  out  2  00 ALU, 01 load data, 10 pc+4, 11 imm.
- `retire_o`  out  1  one-cycle pulse per completed instruction.
- `instret_o`  out  CNT_W  retired count.
- `trap_o`  out  1  sticky trap flag.
- `trap_cause_o`  out  2  01 illegal opcode, 10 fetch timeout, 11 data timeout.

## Operation
- States and transitions:
  - FETCH → DECODE on `imem_ack_i`.
  - DECODE → EXEC, or → TRAP if the opcode is not one of load, store, OP, OP-IMM, branch, `jal`, `jalr`, `lui`, `auipc`.
  - EXEC → MEM for loads and stores.
  - EXEC → FETCH for branches.
  - EXEC → WB for all other instructions.
  - MEM → WB for loads, or → FETCH for stores, on `dmem_ack_i`.
  - WB → FETCH.
  - TRAP is absorbing until reset.
- `imem_req_o` is high throughout FETCH. `instr_o` loads `imem_rdata_i` in the ack cycle.
- Selects and `alu_op_o` are valid from EXEC through WB; they are 0 in FETCH, DECODE and TRAP.
- `alu_op_o` decode for OP and OP-IMM:
  - funct3 maps directly to the codes above.
  - instr[30] selects sub over add for OP only.
  - instr[30] selects sra over srl for both OP and OP-IMM.
  - Every other opcode uses add (0).
- `lui`: `wb_sel_o`=11.
- `auipc`: A = pc, B = imm, `wb_sel_o`=00.
- `jal`: A = pc. `jalr`: A = rs1. Both use B = imm, `wb_sel_o`=10 and `pc_sel_o`=1.
- Branch taken condition, sampled in EXEC:
  - beq: equal. bne: !equal.
  - blt / bltu: less. bge / bgeu: !less.
  - funct3 010 or 011: never taken.
  - `pc_sel_o` = taken.
- `dmem_req_o` is high throughout MEM. `dmem_we_o` = 1 for stores only.
- Wait counter:
  - Clears on entry to FETCH and to MEM, and increments each cycle without an ack.
  - At the `WAIT_MAX`-th wait cycle without an ack, go to TRAP with the matching cause.
  - An ack arriving in that same cycle wins over the timeout.
- Retirement: `instret_o` increments (wrapping modulo 2^CNT_W) in the cycle `retire_o` is high. An instruction that traps never retires.

## Timing
- Reset is asynchronous. On reset:
  - all outputs = 0, except `instr_o` = 32'h0000_0013 (nop);
  - state = FETCH, counters = 0.
- Reset during a pending request drops the request immediately. Any late ack after reset is ignored until the next FETCH request is raised.
- `pc_wren_o` and `retire_o` pulse together for exactly one cycle per instruction:
  - in WB for ALU, jump, `lui`, `auipc` and load instructions;
  - in EXEC for branches;
  - in the MEM ack cycle for stores.
- `rd_wren_o` is high only in WB.
- Latency with zero-wait memories (ack in the first request cycle):
  - branch: 3 cycles;
  - ALU, jump, `lui`, `auipc`, store: 4 cycles;
  - load: 5 cycles.
- In TRAP, all request, enable and strobe outputs are 0, and `trap_o` / `trap_cause_o` hold their values.

## Structure
- `ctrl_pkg` holds:
  - the opcode enum, ALU op enum, FSM state enum;
  - the `wb_sel` constants and trap cause constants;
  - `NOP_INSTR`.
- One combinational sub-module, `alu_dec`, maps (opcode, funct3, instr[30]) → `alu_op_o`.
- The FSM, wait counter, instruction register and retired counter all live in `mc_ctrl_unit`.

## Test plan
- Zero-wait memories: `addi x1,x0,5`, then `sub` → FETCH-DECODE-EXEC-WB each, `alu_op_o`=0 then 9, `instret_o`=2 after 8 cycles.
- `bltu` with less=1 → `br_unsigned_o`=1, `pc_sel_o`=1, `pc_wren_o` in cycle 3. `bge` with less=1 → `pc_sel_o`=0.
- `lw` with `dmem_ack_i` delayed 3 cycles → `dmem_req_o` high for 4 cycles, `dmem_size_o`=10, `rd_wren_o` with `wb_sel_o`=01 one cycle later. `sb` → `dmem_we_o`=1, retire in the ack cycle.
- Timeouts (`WAIT_MAX`=4):
  - `imem_ack_i` held low → `trap_o`=1, cause 10 after 4 wait cycles; stays in TRAP.
  - Ack in the 4th cycle → no trap.
- Opcode 7'b0000000 → TRAP with cause 01, `instret_o` unchanged. Then assert `rst_i` mid-FETCH → outputs 0 immediately, `instr_o`=0x13.
- `CNT_W`=4: 16 retirements → `instret_o` wraps to 0.
